// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped input port: word addresses, bus width
// and per-port switch widths.
package io_pkg;

    localparam int IO_DATA_W = 32;
    localparam int IO_W0     = 4;
    localparam int IO_W1     = 4;
    localparam int IO_W2     = 1;

    typedef enum logic [1:0] {
        IO_ADDR_PORT0  = 2'd0,
        IO_ADDR_PORT1  = 2'd1,
        IO_ADDR_PORT2  = 2'd2,
        IO_ADDR_STATUS = 2'd3
    } io_addr_e;

    function automatic logic [IO_DATA_W-1:0] zext4(input logic [3:0] v);
        return {{(IO_DATA_W-4){1'b0}}, v};
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus debounce for one W-bit input group.
// With IO_INPUT_DB_BYPASS_EN defined the counter is dropped and any synced change is taken next edge.
module io_debounce #(
    parameter int W         = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic         upd
);

    logic [W-1:0] sync1_reg;
    logic [W-1:0] sync2_reg;
    logic [W-1:0] stable_reg;
    logic         differ;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign differ = (sync2_reg != stable_reg);

`ifdef IO_INPUT_DB_BYPASS_EN
    assign upd = differ;
`else
    logic [CNT_W-1:0] cnt_reg;

    // Counter runs only while synced disagrees with stable, so it tops out at DB_CYCLES-1.
    assign upd = differ && (cnt_reg == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (!differ || upd) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            stable_reg <= '0;
        end else if (upd) begin
            stable_reg <= sync2_reg;
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped switch/key input port: three debounced groups, sticky change flags
// with clear-on-read, IRQ, and a one-cycle registered read path. Optional macro: IO_INPUT_DB_BYPASS_EN.
module io_input_port
    import io_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IO_W0-1:0]     sw0,
    input  logic [IO_W1-1:0]     sw1,
    input  logic [IO_W2-1:0]     sw2,
    input  logic                 io_rd,
    input  logic [1:0]           io_addr,
    output logic [IO_DATA_W-1:0] io_rdata,
    output logic                 io_irq
);

    logic [IO_W0-1:0]     stable0;
    logic [IO_W1-1:0]     stable1;
    logic [IO_W2-1:0]     stable2;
    logic [2:0]           upd;
    logic [2:0]           clr;
    logic [2:0]           chg_reg;
    logic [2:0]           chg_next;
    logic [IO_DATA_W-1:0] rdata_reg;
    logic [IO_DATA_W-1:0] rdata_next;

    io_debounce #(.W(IO_W0), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db0 (
        .clock(clock), .reset(reset), .raw(sw0), .stable(stable0), .upd(upd[0])
    );
    io_debounce #(.W(IO_W1), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db1 (
        .clock(clock), .reset(reset), .raw(sw1), .stable(stable1), .upd(upd[1])
    );
    io_debounce #(.W(IO_W2), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db2 (
        .clock(clock), .reset(reset), .raw(sw2), .stable(stable2), .upd(upd[2])
    );

    // Reading a data port clears its flag; a simultaneous debounce update keeps it set.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_clr
            assign clr[gi] = io_rd && (io_addr == 2'(gi));
        end
    endgenerate

    assign chg_next = (chg_reg & ~clr) | upd;

    always_comb begin
        rdata_next = '0;
        case (io_addr)
            IO_ADDR_PORT0:  rdata_next = zext4(stable0);
            IO_ADDR_PORT1:  rdata_next = zext4(stable1);
            IO_ADDR_PORT2:  rdata_next = {{(IO_DATA_W-IO_W2){1'b0}}, stable2};
            IO_ADDR_STATUS: rdata_next = {{(IO_DATA_W-3){1'b0}}, chg_reg};
            default:        rdata_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_reg <= '0;
            chg_reg   <= '0;
        end else begin
            if (io_rd) begin
                rdata_reg <= rdata_next;
            end
            chg_reg <= chg_next;
        end
    end

    assign io_rdata = rdata_reg;
    assign io_irq   = |chg_reg;

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port (DB_CYCLES=4): scripted vector table, hand sequences and
// randomized traffic checked every cycle against a window-based reference model.
module tb_io_input_port;

    localparam int DB = 4;
`ifdef IO_INPUT_DB_BYPASS_EN
    localparam int DBM = 1;
`else
    localparam int DBM = DB;
`endif
    localparam int LAT = 2 + DBM;
    localparam int NH  = 4096;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  sw0, sw1;
    logic        sw2;
    logic        io_rd;
    logic [1:0]  io_addr;
    logic [31:0] io_rdata;
    logic        io_irq;

    int vectors = 0;
    int miscompares = 0;

    io_input_port #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .sw0(sw0), .sw1(sw1), .sw2(sw2),
        .io_rd(io_rd), .io_addr(io_addr), .io_rdata(io_rdata), .io_irq(io_irq)
    );

    always #5 clock = ~clock;

    // Reference model: raw history per port; stable takes the synced value once it has
    // disagreed with stable on each of the last DBM edges since the last update/reset.
    logic [3:0]  m_hist [0:2][0:NH-1];
    logic [3:0]  m_stab [0:2];
    int          m_last [0:2];
    logic [2:0]  m_chg;
    logic [31:0] m_rdata;
    int          k = 0;
    int          rst_edge = 0;

    function automatic logic [3:0] m_synced(input int p, input int j);
        if (j - 2 <= rst_edge) return 4'h0;
        return m_hist[p][j-2];
    endfunction

    task automatic model_edge();
        logic [2:0] upd;
        k++;
        m_hist[0][k] = sw0;
        m_hist[1][k] = sw1;
        m_hist[2][k] = {3'b000, sw2};
        if (reset) begin
            rst_edge = k;
            m_chg    = '0;
            m_rdata  = '0;
            for (int p = 0; p < 3; p++) begin
                m_stab[p] = '0;
                m_last[p] = k;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                upd[p] = 1'b1;
                for (int j = k - DBM + 1; j <= k; j++)
                    if (j <= m_last[p] || m_synced(p, j) == m_stab[p]) upd[p] = 1'b0;
            end
            if (io_rd) begin
                if (io_addr == 2'd3) m_rdata = {29'b0, m_chg};
                else                 m_rdata = {28'b0, m_stab[io_addr]};
            end
            for (int p = 0; p < 3; p++) begin
                if (io_rd && io_addr == 2'(p)) m_chg[p] = 1'b0;
                if (upd[p]) begin
                    m_chg[p]  = 1'b1;
                    m_stab[p] = m_synced(p, k);
                    m_last[p] = k;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, k);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [1:0] a);
        reset   = r;
        io_rd   = rd;
        io_addr = a;
        @(posedge clock);
        model_edge();
        #1;
        check("model_rdata", io_rdata, m_rdata);
        check("model_irq", {31'b0, io_irq}, {31'b0, |m_chg});
        $display("cyc %0d rst=%b sw0=%h sw1=%h sw2=%b rd=%b addr=%0d -> rdata=%h irq=%b",
                 k, r, sw0, sw1, sw2, rd, a, io_rdata, io_irq);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic        s2;
        logic        rd;
        logic [1:0]  addr;
        int          reps;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] s0, input logic [3:0] s1, input logic s2,
                       input logic rd, input logic [1:0] addr, input int reps,
                       input logic [31:0] er, input logic ei);
        vec_t v;
        v.rst = rst; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.rd = rd; v.addr = addr;
        v.reps = reps; v.exp_rdata = er; v.exp_irq = ei;
        tbl.push_back(v);
    endtask

    task automatic check_out(input string tag, input logic [31:0] er, input logic ei);
        check({tag, "_rdata"}, io_rdata, er);
        check({tag, "_irq"}, {31'b0, io_irq}, {31'b0, ei});
    endtask

    initial begin
        reset = 1'b1; sw0 = '0; sw1 = '0; sw2 = 1'b0; io_rd = 1'b0; io_addr = '0;

        add(1, 4'h0, 4'h0, 0, 0, 0, 2,       32'h0, 0);
        add(0, 4'h0, 4'h0, 0, 0, 0, 3,       32'h0, 0);
        add(0, 4'h0, 4'h0, 0, 1, 3, 1,       32'h0, 0);
        add(0, 4'hA, 4'h0, 0, 0, 0, LAT - 1, 32'h0, 0);
        add(0, 4'hA, 4'h0, 0, 0, 0, 1,       32'h0, 1);
        add(0, 4'hA, 4'h0, 0, 1, 0, 1,       32'hA, 0);
        add(0, 4'hA, 4'h0, 0, 1, 3, 1,       32'h0, 0);
`ifndef IO_INPUT_DB_BYPASS_EN
        add(0, 4'hA, 4'hF, 0, 0, 0, 2,       32'h0, 0);
        add(0, 4'hA, 4'h0, 0, 0, 0, 8,       32'h0, 0);
        add(0, 4'hA, 4'h0, 0, 1, 1, 1,       32'h0, 0);
`endif
        add(0, 4'hA, 4'h0, 1, 0, 0, LAT - 1, 32'h0, 0);
        add(0, 4'hA, 4'h0, 1, 1, 2, 1,       32'h0, 1);
        add(0, 4'hA, 4'h0, 1, 1, 3, 1,       32'h4, 1);
        add(0, 4'hA, 4'h0, 1, 1, 2, 1,       32'h1, 0);

        foreach (tbl[i]) begin
            sw0 = tbl[i].s0; sw1 = tbl[i].s1; sw2 = tbl[i].s2;
            for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].rst, tbl[i].rd, tbl[i].addr);
            check_out($sformatf("vec%0d", i), tbl[i].exp_rdata, tbl[i].exp_irq);
        end

        // Reset mid-debounce must discard the partial count.
        sw0 = 4'h7;
        for (int r = 0; r < LAT - 1; r++) step(0, 0, 0);
        check_out("pre_rst", 32'h1, 0);
        step(1, 0, 0);
        check_out("in_rst", 32'h0, 0);
        for (int r = 0; r < LAT - 1; r++) step(0, 0, 0);
        check_out("post_rst_wait", 32'h0, 0);
        step(0, 0, 0);
        check_out("post_rst_upd", 32'h0, 1);
        step(0, 1, 0);
        check_out("post_rst_rd0", 32'h7, 1);
        step(0, 1, 3);
        check_out("post_rst_stat", 32'h4, 1);
        step(0, 1, 2);
        check_out("post_rst_rd2", 32'h1, 0);

`ifdef IO_INPUT_DB_BYPASS_EN
        sw1 = 4'h3;
        step(0, 0, 0);
        step(0, 0, 0);
        check_out("byp_wait", 32'h1, 0);
        step(0, 0, 0);
        check_out("byp_upd", 32'h1, 1);
        step(0, 1, 1);
        check_out("byp_rd1", 32'h3, 0);
`endif

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) sw0 = 4'($urandom);
            if ($urandom_range(9) == 0) sw1 = 4'($urandom);
            if ($urandom_range(5) == 0) sw2 = ~sw2;
            step(($urandom_range(299) == 0), ($urandom_range(2) == 0), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Input-side counterpart to the seven-segment output path.
- Samples raw board switches and key asynchronously, synchronises and debounces them, then presents them as memory-mapped 32-bit words zero-extended from 4 bits.
- Sits beside the data RAM in the MEM stage and is read by the CPU on word-addressed I/O reads.
- Per-port change flags and an IRQ line let software poll or react to input changes.

Parameters:
- DB_CYCLES, default 16: consecutive cycles a new synced value must hold before it is accepted (minimum 2).
- CNT_W, default 5: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sw0  input  4  raw switch group 0, asynchronous.
- sw1  input  4  raw switch group 1, asynchronous.
- sw2  input  1  raw key (branch select), asynchronous.
- io_rd  input  1  read strobe for one cycle.
- io_addr  input  2  word index: 0 = port0, 1 = port1, 2 = port2, 3 = status.
- io_rdata  output  32  read data, valid the cycle after io_rd.
- io_irq  output  1  high while any change flag is set.

Behaviour:
- Synchronisation:
  - Every raw bit passes through a 2-flop synchroniser.
  - Synced value appears 2 cycles after the raw change.
- Debounce, per port (widths 4, 4, 1):
  - Holds a stable value and a counter.
  - If synced == stable: counter is set to 0.
  - Else: counter increments.
  - When the counter reaches DB_CYCLES-1 with synced != stable:
    - stable <= synced
    - counter <= 0
    - chg[n] <= 1
  - A glitch shorter than DB_CYCLES cycles never updates stable.
  - Latency from raw edge to stable update is 2 + DB_CYCLES cycles.
- Read:
  - On a cycle with io_rd=1, io_rdata is registered at that edge and is valid on the following cycle.
  - This one-cycle latency matches the data-RAM read path.
  - io_rdata holds its value until the next io_rd.
  - Data layout by address:
    - port0: {28'b0, stable0}
    - port1: {28'b0, stable1}
    - port2: {31'b0, stable2}
    - status: {29'b0, chg2, chg1, chg0}
- Clear-on-read:
  - Reading port n clears chg[n] at the same edge.
  - If a debounce update on port n happens in that same cycle, set wins and chg[n] stays 1.
  - The returned data is the pre-update stable value.
  - Reading status clears nothing.
- io_irq = chg0 | chg1 | chg2, combinational from the flags.
- Reset:
  - Synchronisers, stable values, counters, chg flags and io_rdata all go to 0; io_irq is therefore 0.
  - Raw inputs already high at reset release produce a debounced update and set chg after 2 + DB_CYCLES cycles.
  - Asserting reset mid-debounce discards the partial count.
- Counter width: the counter never exceeds DB_CYCLES-1, so it cannot wrap.

Optional Feature:
- Macro: IO_INPUT_DB_BYPASS_EN.
- Defined:
  - The debounce counter is removed.
  - stable <= synced whenever they differ, one cycle after the synced change; chg is set on that same edge.
  - Total latency is 3 cycles.
  - Intended for fast simulation.
- Undefined: full debounce as described above.
- Read path and flag behaviour are identical in both builds.

Decomposition:
- Shared package io_pkg:
  - Address constants IO_ADDR_PORT0/1/2 and IO_ADDR_STATUS.
  - IO_DATA_W = 32.
  - Port widths 4/4/1.
- Sub-module io_debounce, parameterised by width W and DB_CYCLES:
  - Contains the synchroniser, counter, stable register and one-cycle update pulse.
  - Instantiated three times; the top level holds the chg flags and the read mux.

Test Plan (DB_CYCLES = 4):
- Reset then idle, read addr 3 -> io_rdata = 0x0000_0000, io_irq = 0.
- sw0 = 4'b1010 held -> stable0 updates 6 cycles later, io_irq = 1; read addr 0 -> 0x0000_000A; next read of addr 3 -> 0x0000_0000, io_irq = 0.
- sw1 pulses to 4'hF for 2 cycles, then back to 0 -> no update, chg1 stays 0, read addr 1 -> 0x0000_0000.
- sw2 set to 1 and held; read addr 2 issued on the exact cycle of the debounce update -> returns 0x0000_0000, chg2 remains 1; a second read returns 0x0000_0001 and clears chg2.
- sw0 = 4'h7 held for 3 cycles after sync, reset asserted for 1 cycle, then sw0 still 7 -> stable0 updates only 2 + 4 cycles after reset deasserts.
- IO_INPUT_DB_BYPASS_EN defined, sw1 = 4'h3 -> chg1 set 3 cycles after the raw change; read addr 1 -> 0x0000_0003.
